// File: rtl/mem_burst_arbiter_pkg.sv
// rtl/mem_burst_arbiter_pkg.sv - shared types and defaults for the burst read-port arbiter
package mem_burst_arbiter_pkg;

  localparam int DEF_N_REQ  = 2;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 7;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Requester i owns bits [width*(i+1)-1 : width*i] of a packed per-requester bus.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mem_burst_arbiter_rr_pick.sv
// rtl/mem_burst_arbiter_rr_pick.sv - combinational round-robin selector, first set bit from ptr upward
module rr_pick
  import mem_burst_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W:0]   sum;
  logic             found;

  // Rotate so that the requester at ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    rot       = N_REQ'({req_i, req_i} >> ptr_i);
    found     = 1'b0;
    sum       = '0;
    gnt_idx_o = '0;
    for (int off = 0; off < N_REQ; off++) begin
      if (!found && rot[off]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (IDX_W+1)'(off);
        if (sum >= (IDX_W+1)'(N_REQ)) begin
          sum = sum - (IDX_W+1)'(N_REQ);
        end
        gnt_idx_o = sum[IDX_W-1:0];
      end
    end
    gnt_oh_o = '0;
    for (int j = 0; j < N_REQ; j++) begin
      gnt_oh_o[j] = found && (gnt_idx_o == IDX_W'(j));
    end
  end

  assign valid_o = found;

endmodule

// File: rtl/mem_burst_arbiter.sv
// rtl/mem_burst_arbiter.sv - round-robin burst arbiter for the shared character/display RAM read port
module mem_burst_arbiter
  import mem_burst_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] base_addr_i,
  input  logic [N_REQ*LEN_W-1:0]  burst_len_i,
  output logic [N_REQ-1:0]        grant_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_rd_o,
  input  logic [DATA_W-1:0]       mem_data_i,
  output logic                    rd_valid_o,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic [LEN_W-1:0]        rd_idx_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e            state_q;
  logic [N_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              mem_rd_q;
  logic              zlen_q;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pl_q;
  logic [LEN_W-1:0]  pi_q [RD_LAT];

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_oh;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] sel_base;
  logic [LEN_W-1:0]  sel_len;
  logic              is_last;
  logic              drain_ok;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i     (req_i),
    .ptr_i     (ptr_q),
    .valid_o   (pick_valid),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  assign sel_base = base_addr_i[slice_lsb(int'(pick_idx), ADDR_W) +: ADDR_W];
  assign sel_len  = burst_len_i[slice_lsb(int'(pick_idx), LEN_W) +: LEN_W];
  assign is_last  = (cnt_q == len_q - LEN_W'(1));

  // The output stage may still hold the final byte; leaving DRAIN only needs the earlier stages empty.
  always_comb begin
    drain_ok = 1'b1;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (pv_q[i]) begin
        drain_ok = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= '0;
      base_q     <= '0;
      mem_addr_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      mem_rd_q   <= 1'b0;
      zlen_q     <= 1'b0;
    end else begin
      zlen_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_oh;
            ptr_q   <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
            base_q  <= sel_base;
            len_q   <= sel_len;
            cnt_q   <= '0;
            if (sel_len == '0) begin
              state_q <= ST_DRAIN;
              zlen_q  <= 1'b1;
            end else begin
              state_q    <= ST_ISSUE;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= sel_base;
            end
          end
        end
        ST_ISSUE: begin
          if (is_last) begin
            state_q    <= ST_DRAIN;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
          end else begin
            cnt_q      <= cnt_q + LEN_W'(1);
            mem_addr_q <= base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pi_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= mem_rd_q;
      pl_q[0] <= mem_rd_q & is_last;
      pi_q[0] <= mem_rd_q ? cnt_q : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
    end
  end

  assign grant_o    = grant_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o   = mem_rd_q;
  assign rd_valid_o = pv_q[RD_LAT-1];
  assign rd_idx_o   = pi_q[RD_LAT-1];
  assign rd_data_o  = mem_data_i;
  assign done_o     = grant_q & {N_REQ{(pv_q[RD_LAT-1] & pl_q[RD_LAT-1]) | zlen_q}};
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb/tb_mem_burst_arbiter.sv - directed self-checking bench for mem_burst_arbiter
module tb_mem_burst_arbiter;

  logic        clk;
  logic        rst_n, rst3_n;
  logic [1:0]  req, req3;
  logic [25:0] base, base3;
  logic [13:0] len, len3;
  logic [1:0]  grant, grant3, done, done3;
  logic [12:0] mem_addr, mem_addr3;
  logic        mem_rd, mem_rd3, rd_valid, rd_valid3, busy, busy3;
  logic [7:0]  mem_data, mem_data3, rd_data, rd_data3, m3a, m3b;
  logic [6:0]  rd_idx, rd_idx3;

  int n_pass = 0;
  int n_total = 0;

  mem_burst_arbiter #(.N_REQ(2), .ADDR_W(13), .DATA_W(8), .LEN_W(7), .RD_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .base_addr_i(base), .burst_len_i(len),
    .grant_o(grant), .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_data_i(mem_data),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_idx_o(rd_idx), .done_o(done), .busy_o(busy)
  );

  mem_burst_arbiter #(.N_REQ(2), .ADDR_W(13), .DATA_W(8), .LEN_W(7), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .req_i(req3), .base_addr_i(base3), .burst_len_i(len3),
    .grant_o(grant3), .mem_addr_o(mem_addr3), .mem_rd_o(mem_rd3), .mem_data_i(mem_data3),
    .rd_valid_o(rd_valid3), .rd_data_o(rd_data3), .rd_idx_o(rd_idx3), .done_o(done3), .busy_o(busy3)
  );

  function automatic logic [7:0] memf(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= memf(mem_addr);
  always @(posedge clk) begin
    m3a       <= memf(mem_addr3);
    m3b       <= m3a;
    mem_data3 <= m3b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 2'b01;
    base  = '0;
    len   = {7'd3, 7'd3};
    step();
    n_total++; if (grant !== 2'b00) $display("FAIL reset_grant got %b want 00", grant); else n_pass++;
    n_total++; if (mem_rd !== 1'b0) $display("FAIL reset_mem_rd got %b want 0", mem_rd); else n_pass++;
    n_total++; if (mem_addr !== 13'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
    n_total++; if (rd_valid !== 1'b0 || rd_idx !== 7'd0) $display("FAIL reset_rd got v=%b idx=%0d want 0/0", rd_valid, rd_idx); else n_pass++;
    n_total++; if (done !== 2'b00 || busy !== 1'b0) $display("FAIL reset_done_busy got %b/%b want 00/0", done, busy); else n_pass++;
    req   = 2'b00;
    rst_n = 1'b1;
    step();
    n_total++; if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL idle_no_req got busy=%b grant=%b want 0/00", busy, grant); else n_pass++;
  endtask

  task automatic test_single_burst();
    int ni, nv, nd, bad_a, bad_v, first_rd, first_v;
    logic [12:0] ea;
    do_reset();
    base[12:0] = 13'h800;
    len[6:0]   = 7'd100;
    req        = 2'b01;
    step();
    n_total++; if (grant !== 2'b01 || mem_rd !== 1'b1 || busy !== 1'b1) $display("FAIL single_first_cycle got grant=%b rd=%b busy=%b want 01/1/1", grant, mem_rd, busy); else n_pass++;
    req = 2'b00;
    ni = 0; nv = 0; nd = 0; bad_a = 0; bad_v = 0; first_rd = -1; first_v = -1;
    for (int c = 0; c < 110; c++) begin
      if (mem_rd) begin
        ea = 13'h800 + 13'(ni);
        if (mem_addr !== ea || grant !== 2'b01) bad_a++;
        if (ni == 0) first_rd = c;
        ni++;
      end
      if (rd_valid) begin
        ea = 13'h800 + 13'(nv);
        if (rd_idx !== 7'(nv) || rd_data !== memf(ea)) bad_v++;
        if (nv == 0) first_v = c;
        nv++;
      end
      if (done !== 2'b00) begin
        nd++;
        n_total++; if (done !== 2'b01 || rd_idx !== 7'd99) $display("FAIL single_done_pos got done=%b idx=%0d want 01/99", done, rd_idx); else n_pass++;
      end
      step();
    end
    n_total++; if (ni != 100 || bad_a != 0) $display("FAIL single_addrs got %0d issues %0d bad want 100/0", ni, bad_a); else n_pass++;
    n_total++; if (nv != 100 || bad_v != 0) $display("FAIL single_data got %0d valid %0d bad want 100/0", nv, bad_v); else n_pass++;
    n_total++; if (first_v != first_rd + 1) $display("FAIL single_latency got %0d want %0d", first_v, first_rd + 1); else n_pass++;
    n_total++; if (nd != 1) $display("FAIL single_done_count got %0d want 1", nd); else n_pass++;
    n_total++; if (grant !== 2'b00 || busy !== 1'b0) $display("FAIL single_end got grant=%b busy=%b want 00/0", grant, busy); else n_pass++;
  endtask

  task automatic test_contention();
    logic [1:0]  seq [4];
    logic [1:0]  prev;
    logic [12:0] ea;
    int ngr, idle_run, gap_bad, bad_own, inv_bad, cnt;
    do_reset();
    base = {13'h200, 13'h100};
    len  = {7'd4, 7'd4};
    req  = 2'b11;
    prev = 2'b00; ngr = 0; idle_run = 0; gap_bad = 0; bad_own = 0; inv_bad = 0; cnt = 0;
    for (int i = 0; i < 4; i++) seq[i] = 2'b00;
    for (int c = 0; c < 60; c++) begin
      step();
      if (grant !== 2'b00 && prev === 2'b00) begin
        if (ngr > 0 && idle_run != 1) gap_bad++;
        if (ngr < 4) seq[ngr] = grant;
        ngr++;
        cnt = 0;
        if (ngr == 4) req = 2'b00;
      end
      if (grant === 2'b00) idle_run++; else idle_run = 0;
      if (mem_rd) begin
        ea = ((grant === 2'b01) ? 13'h100 : 13'h200) + 13'(cnt);
        if (mem_addr !== ea || !(grant === 2'b01 || grant === 2'b10)) bad_own++;
        cnt++;
      end
      if (grant === 2'b11 || (done & ~grant) !== 2'b00) inv_bad++;
      prev = grant;
    end
    n_total++; if (ngr != 4) $display("FAIL cont_grant_count got %0d want 4", ngr); else n_pass++;
    n_total++; if (seq[0] !== 2'b01) $display("FAIL cont_order0 got %b want 01", seq[0]); else n_pass++;
    n_total++; if (seq[1] !== 2'b10) $display("FAIL cont_order1 got %b want 10", seq[1]); else n_pass++;
    n_total++; if (seq[2] !== 2'b01) $display("FAIL cont_order2 got %b want 01", seq[2]); else n_pass++;
    n_total++; if (seq[3] !== 2'b10) $display("FAIL cont_order3 got %b want 10", seq[3]); else n_pass++;
    n_total++; if (gap_bad != 0) $display("FAIL cont_idle_gap got %0d bad gaps want 0", gap_bad); else n_pass++;
    n_total++; if (bad_own != 0 || inv_bad != 0) $display("FAIL cont_ownership got %0d/%0d want 0/0", bad_own, inv_bad); else n_pass++;
  endtask

  task automatic test_wrap_len0();
    logic [12:0] addrs [4];
    int n;
    do_reset();
    base[12:0] = 13'h1FFE;
    len        = {7'd0, 7'd4};
    req        = 2'b01;
    step();
    req = 2'b00;
    n = 0;
    for (int i = 0; i < 4; i++) addrs[i] = '0;
    for (int c = 0; c < 10; c++) begin
      if (mem_rd) begin
        if (n < 4) addrs[n] = mem_addr;
        n++;
      end
      step();
    end
    n_total++; if (n != 4) $display("FAIL wrap_count got %0d want 4", n); else n_pass++;
    n_total++; if (addrs[0] !== 13'h1FFE || addrs[1] !== 13'h1FFF) $display("FAIL wrap_hi got %h %h want 1ffe 1fff", addrs[0], addrs[1]); else n_pass++;
    n_total++; if (addrs[2] !== 13'h0000 || addrs[3] !== 13'h0001) $display("FAIL wrap_lo got %h %h want 0000 0001", addrs[2], addrs[3]); else n_pass++;
    req = 2'b10;
    step();
    req = 2'b00;
    n_total++; if (grant !== 2'b10 || done !== 2'b10) $display("FAIL len0_pulse got grant=%b done=%b want 10/10", grant, done); else n_pass++;
    n_total++; if (mem_rd !== 1'b0 || rd_valid !== 1'b0) $display("FAIL len0_no_read got rd=%b v=%b want 0/0", mem_rd, rd_valid); else n_pass++;
    step();
    n_total++; if (grant !== 2'b00 || done !== 2'b00 || busy !== 1'b0) $display("FAIL len0_end got grant=%b done=%b busy=%b want 00/00/0", grant, done, busy); else n_pass++;
  endtask

  task automatic test_disturb();
    logic [12:0] ea;
    int ni, nd, bad, hit5;
    do_reset();
    base = {13'h0, 13'h040};
    len  = {7'd10, 7'd10};
    req  = 2'b01;
    step();
    ni = 0; nd = 0; bad = 0;
    for (int c = 0; c < 30; c++) begin
      if (mem_rd) begin
        ea = 13'h040 + 13'(ni);
        if (mem_addr !== ea) bad++;
        if (ni == 3) begin
          req        = 2'b00;
          base[12:0] = 13'h300;
        end
        ni++;
      end
      if (done !== 2'b00) nd++;
      step();
    end
    n_total++; if (ni != 10 || bad != 0) $display("FAIL disturb_addrs got %0d issues %0d bad want 10/0", ni, bad); else n_pass++;
    n_total++; if (nd != 1) $display("FAIL disturb_done got %0d want 1", nd); else n_pass++;
    base[12:0] = 13'h040;
    req = 2'b01;
    step();
    ni = 0; hit5 = 0;
    for (int c = 0; c < 20 && hit5 == 0; c++) begin
      if (mem_rd) begin
        if (ni == 5) hit5 = 1;
        ni++;
      end
      if (hit5 == 0) step();
    end
    n_total++; if (hit5 != 1) $display("FAIL disturb_byte5 got reached=%0d want 1", hit5); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (grant !== 2'b00 || mem_rd !== 1'b0 || mem_addr !== 13'h0) $display("FAIL async_rst_port got grant=%b rd=%b addr=%h want 00/0/0", grant, mem_rd, mem_addr); else n_pass++;
    n_total++; if (rd_valid !== 1'b0 || rd_idx !== 7'd0 || done !== 2'b00 || busy !== 1'b0) $display("FAIL async_rst_rd got v=%b idx=%0d done=%b busy=%b want 0/0/00/0", rd_valid, rd_idx, done, busy); else n_pass++;
    req = 2'b00;
    nd = 0;
    repeat (2) begin step(); if (done !== 2'b00) nd++; end
    rst_n = 1'b1;
    repeat (5) begin step(); if (done !== 2'b00 || grant !== 2'b00) nd++; end
    n_total++; if (nd != 0) $display("FAIL rst_no_done got %0d pulses want 0", nd); else n_pass++;
    req = 2'b11;
    step();
    req = 2'b00;
    n_total++; if (grant !== 2'b01) $display("FAIL rst_ptr_zero got grant=%b want 01", grant); else n_pass++;
    for (int c = 0; c < 30 && busy; c++) step();
    n_total++; if (busy !== 1'b0) $display("FAIL disturb_drain got busy=%b want 0", busy); else n_pass++;
  endtask

  task automatic test_rdlat3();
    int rdc [5];
    int ni, nv, nd, gcyc, bad, busy_bad, grant_bad, done_c;
    logic [12:0] ea;
    base3[12:0] = 13'h0A0;
    len3        = {7'd0, 7'd5};
    req3        = 2'b01;
    step();
    req3 = 2'b00;
    ni = 0; nv = 0; nd = 0; gcyc = 0; bad = 0; busy_bad = 0; grant_bad = 0; done_c = -1;
    for (int i = 0; i < 5; i++) rdc[i] = -100;
    for (int c = 0; c < 20; c++) begin
      if (grant3 !== 2'b00) gcyc++;
      if (mem_rd3) begin
        if (ni < 5) rdc[ni] = c;
        ni++;
      end
      if (rd_valid3) begin
        ea = 13'h0A0 + 13'(nv);
        if (nv >= 5 || rd_idx3 !== 7'(nv) || c != rdc[nv] + 3 || rd_data3 !== memf(ea)) bad++;
        nv++;
      end
      if (nd == 0) begin
        if (busy3 !== 1'b1) busy_bad++;
        if (grant3 !== 2'b01) grant_bad++;
      end
      if (done3 !== 2'b00) begin
        nd++;
        done_c = c;
      end
      step();
    end
    n_total++; if (ni != 5 || nv != 5 || bad != 0) $display("FAIL lat3_valid got issues=%0d valid=%0d bad=%0d want 5/5/0", ni, nv, bad); else n_pass++;
    n_total++; if (nd != 1 || done_c != 7) $display("FAIL lat3_done got count=%0d cycle=%0d want 1/7", nd, done_c); else n_pass++;
    n_total++; if (gcyc != 8) $display("FAIL lat3_grant_cycles got %0d want 8", gcyc); else n_pass++;
    n_total++; if (busy_bad != 0 || grant_bad != 0) $display("FAIL lat3_hold got busy_bad=%0d grant_bad=%0d want 0/0", busy_bad, grant_bad); else n_pass++;
    n_total++; if (busy3 !== 1'b0) $display("FAIL lat3_end_busy got %b want 0", busy3); else n_pass++;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    req    = 2'b00;
    req3   = 2'b00;
    base   = '0;
    base3  = '0;
    len    = '0;
    len3   = '0;
    step();
    test_reset();
    rst3_n = 1'b1;
    step();
    test_single_burst();
    test_contention();
    test_wrap_len0();
    test_disturb();
    test_rdlat3();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single synchronous read port of the on-chip character/display RAM (13-bit address, 8-bit data) between N_REQ burst requesters, such as line-buffer refresh loaders.
- Each requester asks for a contiguous burst given by a base address and a length.
- The arbiter grants one requester at a time, round-robin, and generates the addresses.
- It returns data tagged with its byte index, which the winner uses to steer its per-byte register enables.

Parameters:
N_REQ, 2, number of requesters (2..8)
ADDR_W, 13, memory address width
DATA_W, 8, memory data width
LEN_W, 7, burst length width (max burst 2^LEN_W-1 bytes)
RD_LAT, 1, memory read latency in cycles (1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  N_REQ  per-requester burst request, level
base_addr  in  N_REQ*ADDR_W  packed start addresses; slice i = [ADDR_W*(i+1)-1 : ADDR_W*i]
burst_len  in  N_REQ*LEN_W  packed burst lengths, same packing
grant  out  N_REQ  one-hot owner of the port, held for the whole burst
mem_addr  out  ADDR_W  RAM read address
mem_rd  out  1  RAM read strobe
mem_data  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_rd
rd_valid  out  1  rd_data/rd_idx valid for the granted requester
rd_data  out  DATA_W  pass-through of mem_data
rd_idx  out  LEN_W  byte index within the burst, 0..len-1
done  out  N_REQ  one-cycle pulse on the granted bit with the final byte
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE.
  - grant, mem_rd, rd_valid, done, busy = 0.
  - mem_addr = 0, rd_idx = 0.
  - Round-robin pointer = 0.
  - Read pipeline flushed.
  - A reset mid-burst aborts it silently; no done pulse.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any req bit is set, select the first set bit scanning from ptr upward, with wrap.
  - Latch that requester's base and len.
  - Register grant one-hot, and set ptr = winner+1 mod N_REQ.
  - Go to ISSUE, or to DRAIN if len=0.
  - If no req bit is set, stay in IDLE.
- ISSUE:
  - Each cycle: mem_rd=1, mem_addr=base+cnt (mod 2^ADDR_W, wraps silently), cnt++.
  - When cnt==len-1, this is the last issue; go to DRAIN.
- DRAIN:
  - Wait until the read pipeline is empty, then return to IDLE.
  - grant stays high through the cycle carrying done.
- Outside ISSUE: mem_rd=0 and mem_addr=0.
- Read pipeline:
  - An RD_LAT-deep shift of {valid, idx, last}.
  - rd_valid/rd_idx appear exactly RD_LAT cycles after the matching mem_rd.
  - rd_data = mem_data, combinational.
  - done[winner] = rd_valid & last.
- len=0:
  - grant is high for one cycle, with done[winner] pulsed in that same cycle.
  - No mem_rd and no rd_valid.
- Timing:
  - req is sampled at edge k.
  - grant and the first mem_rd appear in cycle k+1.
  - The first rd_valid appears in cycle k+1+RD_LAT.
  - done coincides with rd_valid for idx len-1.
  - grant drops in the following cycle (IDLE).
  - Earliest next grant is one cycle after that.
  - Burst occupancy = len+RD_LAT cycles, plus 1 IDLE cycle.
- Request handling:
  - req, base_addr and burst_len are sampled only in IDLE; changes mid-burst are ignored.
  - A req dropping mid-burst does not abort the burst.
  - A requester holding req after done is re-granted only when its round-robin turn comes again.
- Simultaneous requests: resolved by ptr; no requester waits more than N_REQ-1 bursts.
- Invariants: grant is always one-hot or zero, and done ⊆ grant.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/DRAIN localparams), default widths, and the packing-slice convention for base_addr/burst_len.
- One sub-module, rr_pick: a combinational round-robin selector.
  - Inputs: req vector and ptr.
  - Outputs: one-hot winner and binary index.
  - Reusable by other shared-resource arbiters.
- Counter and read pipeline stay inline.

Test Plan:
- Single burst, RD_LAT=1: req[0]=1, base 0x800, len 100.
  - grant=01.
  - mem_addr 0x800..0x863 on 100 consecutive cycles.
  - rd_idx 0..99 one cycle later.
  - done[0] exactly once, with rd_idx=99.
- Contention: req=11 held, len 4 each.
  - Grant order is 0, 1, 0, 1.
  - Exactly 1 IDLE cycle between bursts.
  - No overlap of mem_rd ownership.
- Wrap and len edge cases:
  - base 0x1FFE, len 4 -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
  - len=0 -> one-cycle grant plus done, no mem_rd.
- Mid-burst disturbance, len 10:
  - req[0] drops, and base_addr[0] changes, at byte 3.
  - The burst still issues all 10 original addresses, and done[0] pulses.
  - Reset asserted at byte 5: all outputs are 0 asynchronously, no done, ptr=0 after release.
- RD_LAT=3, len 5:
  - rd_valid is delayed 3 cycles from each mem_rd.
  - busy stays high until done.
  - grant is held through the DRAIN cycles.
